// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - run-control bundle between debug unit, fetch/decode stages and the sequencer
interface pipeline_sequencer_if #(
  parameter int NB        = 32,
  parameter int NB_CYCLES = 32
);
  logic                 i_run;
  logic                 i_step;
  logic                 i_stop;
  logic [NB-1:0]        i_instruction;
  logic                 i_instruction_valid;
  logic                 o_pc_enable;
  logic                 o_pipeline_enable;
  logic                 o_flush;
  logic                 o_busy;
  logic                 o_done;
  logic [2:0]           o_state;
  logic [NB_CYCLES-1:0] o_cycle_count;

  modport master (
    output i_run, i_step, i_stop, i_instruction, i_instruction_valid,
    input  o_pc_enable, o_pipeline_enable, o_flush, o_busy, o_done, o_state, o_cycle_count
  );

  modport slave (
    input  i_run, i_step, i_stop, i_instruction, i_instruction_valid,
    output o_pc_enable, o_pipeline_enable, o_flush, o_busy, o_done, o_state, o_cycle_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - run/step/halt-drain sequencer gating the MIPS PC and pipeline-register enables
module pipeline_sequencer #(
  parameter int                    NB           = 32,
  parameter int                    NB_OPCODE    = 6,
  parameter logic [NB_OPCODE-1:0]  HALT_OPCODE  = 6'b111111,
  parameter int                    DRAIN_CYCLES = 4,
  parameter int                    NB_CYCLES    = 32
) (
  input logic                  i_clk,
  input logic                  i_reset,
  pipeline_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int                  NB_DRAIN   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  state_e               state_q, state_d;
  logic [NB_DRAIN-1:0]  drain_q, drain_d;
  logic [NB_CYCLES-1:0] count_q, count_d;
  logic                 pc_en_q, pipe_en_q, flush_q, busy_q, done_q;
  logic                 halt;

  assign halt = bus.i_instruction_valid && (bus.i_instruction[NB-1 -: NB_OPCODE] == HALT_OPCODE);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    count_d = count_q;
    if (pipe_en_q && (count_q != '1)) begin
      count_d = count_q + NB_CYCLES'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (bus.i_run) begin
          state_d = S_RUN;
        end else if (bus.i_step) begin
          state_d = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        // halt outranks a concurrent stop; a step always falls back to IDLE
        if (halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (bus.i_stop || (state_q == S_STEP)) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - NB_DRAIN'(1);
        end
      end
      S_DONE: begin
        if (bus.i_stop) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      drain_q   <= '0;
      count_q   <= '0;
      pc_en_q   <= 1'b0;
      pipe_en_q <= 1'b0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      count_q   <= count_d;
      pc_en_q   <= (state_d == S_RUN) || (state_d == S_STEP);
      pipe_en_q <= (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
      flush_q   <= (state_d == S_DRAIN);
      busy_q    <= (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign bus.o_state           = state_q;
  assign bus.o_pc_enable       = pc_en_q;
  assign bus.o_pipeline_enable = pipe_en_q;
  assign bus.o_flush           = flush_q;
  assign bus.o_busy            = busy_q;
  assign bus.o_done            = done_q;
  assign bus.o_cycle_count     = count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - scoreboard bench for pipeline_sequencer with a cycle-level reference model
module tb_pipeline_sequencer;

  localparam int          DRAIN = 4;
  localparam logic [31:0] HALT  = 32'hFC00_0000;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef struct packed {
    logic [2:0]  st;
    logic        pc;
    logic        pipe;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t sb[$];

  int      m_mode = 0;
  int      m_left = 0;
  longint  m_count = 0;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.NB(32), .NB_CYCLES(32)) bus ();
  pipeline_sequencer_if #(.NB(32), .NB_CYCLES(4))  bus4 ();

  pipeline_sequencer #(.NB(32), .NB_OPCODE(6), .HALT_OPCODE(6'b111111),
                       .DRAIN_CYCLES(DRAIN), .NB_CYCLES(32)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus.slave)
  );

  pipeline_sequencer #(.NB(32), .NB_OPCODE(6), .HALT_OPCODE(6'b111111),
                       .DRAIN_CYCLES(DRAIN), .NB_CYCLES(4)) dut4 (
    .i_clk(clk), .i_reset(rst4), .bus(bus4.slave)
  );

  // Behavioural model: mode 0..4 = IDLE/RUN/STEP/DRAIN/DONE, m_left = drain cycles still owed
  task automatic model(input bit r, input bit run, input bit step, input bit stop, input bit halt);
    if (r) begin
      m_mode = 0; m_left = 0; m_count = 0;
    end else begin
      if ((m_mode == 1 || m_mode == 2 || m_mode == 3) && m_count < 64'hFFFF_FFFF) m_count++;
      case (m_mode)
        0: if (run) m_mode = 1; else if (step) m_mode = 2;
        1: if (halt) begin m_mode = 3; m_left = DRAIN; end else if (stop) m_mode = 0;
        2: if (halt) begin m_mode = 3; m_left = DRAIN; end else m_mode = 0;
        3: begin m_left--; if (m_left == 0) m_mode = 4; end
        default: if (stop) begin m_mode = 0; m_count = 0; end
      endcase
    end
  endtask

  function automatic obs_t expected();
    obs_t e;
    e.st    = 3'(m_mode);
    e.pc    = (m_mode == 1 || m_mode == 2);
    e.pipe  = (m_mode == 1 || m_mode == 2 || m_mode == 3);
    e.flush = (m_mode == 3);
    e.busy  = e.pipe;
    e.done  = (m_mode == 4);
    e.cnt   = 32'(m_count);
    return e;
  endfunction

  task automatic cyc(input bit r, input bit run, input bit step, input bit stop,
                     input logic [31:0] ins, input bit vld);
    @(negedge clk);
    rst = r;
    bus.i_run = run; bus.i_step = step; bus.i_stop = stop;
    bus.i_instruction = ins; bus.i_instruction_valid = vld;
    model(r, run, step, stop, vld && (ins[31:26] == 6'h3F));
    sb.push_back(expected());
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, NOP, 1);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, NOP, 0);
    cyc(1, 0, 0, 0, NOP, 0);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {bus.o_state, bus.o_pc_enable, bus.o_pipeline_enable, bus.o_flush,
             bus.o_busy, bus.o_done, bus.o_cycle_count};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_obs t=%0t: got st=%0d pc=%b pipe=%b fl=%b busy=%b done=%b cnt=%0d expected st=%0d pc=%b pipe=%b fl=%b busy=%b done=%b cnt=%0d",
                   $time, a.st, a.pc, a.pipe, a.flush, a.busy, a.done, a.cnt,
                   e.st, e.pc, e.pipe, e.flush, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] ins;
    bus.i_run = 0; bus.i_step = 0; bus.i_stop = 0;
    bus.i_instruction = NOP; bus.i_instruction_valid = 0;
    bus4.i_run = 0; bus4.i_step = 0; bus4.i_stop = 0;
    bus4.i_instruction = NOP; bus4.i_instruction_valid = 0;

    // reset with run and step held high
    cyc(1, 1, 1, 0, NOP, 0);
    cyc(1, 1, 1, 0, NOP, 0);
    settle();
    chk("reset_state", bus.o_state, 0);
    chk("reset_pipe_en", bus.o_pipeline_enable, 0);
    chk("reset_count", bus.o_cycle_count, 0);
    cyc(0, 1, 0, 0, NOP, 1);
    settle();
    chk("run_after_release", bus.o_state, 1);

    // run 10 cycles, pause, resume
    do_reset();
    cyc(0, 1, 0, 0, NOP, 1);
    repeat (9) idle_cyc();
    cyc(0, 0, 0, 1, NOP, 1);
    settle();
    chk("pause_state", bus.o_state, 0);
    chk("pause_count", bus.o_cycle_count, 10);
    cyc(0, 1, 0, 0, NOP, 1);
    idle_cyc();
    idle_cyc();
    settle();
    chk("resume_count", bus.o_cycle_count, 12);
    cyc(0, 0, 0, 1, NOP, 1);

    // three spaced single steps
    do_reset();
    repeat (3) begin
      cyc(0, 0, 1, 0, NOP, 1);
      repeat (3) idle_cyc();
    end
    settle();
    chk("step_count", bus.o_cycle_count, 3);
    chk("step_state", bus.o_state, 0);

    // halt on the 6th RUN cycle, stop ignored while draining
    do_reset();
    cyc(0, 1, 0, 0, NOP, 1);
    repeat (5) idle_cyc();
    cyc(0, 0, 0, 0, HALT, 1);
    settle();
    chk("drain_state", bus.o_state, 3);
    chk("drain_pc_en", bus.o_pc_enable, 0);
    chk("drain_flush", bus.o_flush, 1);
    repeat (4) cyc(0, 0, 0, 1, NOP, 1);
    settle();
    chk("done_flag", bus.o_done, 1);
    chk("done_count", bus.o_cycle_count, 10);
    cyc(0, 1, 0, 0, NOP, 1);
    settle();
    chk("done_ignores_run", bus.o_state, 4);
    cyc(0, 0, 0, 1, NOP, 1);
    settle();
    chk("ack_state", bus.o_state, 0);
    chk("ack_count", bus.o_cycle_count, 0);

    // halt opcode on a bubble
    do_reset();
    cyc(0, 1, 0, 0, NOP, 1);
    cyc(0, 0, 0, 0, HALT, 0);
    settle();
    chk("bubble_no_halt", bus.o_state, 1);
    cyc(0, 0, 0, 1, NOP, 1);

    // run and step together, then halt and stop together
    do_reset();
    cyc(0, 1, 1, 0, NOP, 1);
    settle();
    chk("run_beats_step", bus.o_state, 1);
    cyc(0, 0, 0, 1, HALT, 1);
    settle();
    chk("halt_beats_stop", bus.o_state, 3);

    // reset in the 2nd drain cycle
    do_reset();
    cyc(0, 1, 0, 0, NOP, 1);
    cyc(0, 0, 0, 0, HALT, 1);
    idle_cyc();
    cyc(1, 0, 0, 0, NOP, 1);
    settle();
    chk("reset_in_drain", bus.o_state, 0);
    repeat (6) idle_cyc();

    // randomized traffic
    do_reset();
    repeat (400) begin
      ins = $urandom;
      if ($urandom_range(0, 5) == 0) ins[31:26] = 6'h3F;
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, ins, $urandom_range(0, 3) != 0);
    end
    idle_cyc();
    settle();
    settle();
    chk("scoreboard_drained", sb.size(), 0);

    // 4-bit counter saturates at 15
    @(negedge clk);
    rst4 = 1'b0;
    bus4.i_run = 1'b1;
    repeat (20) @(negedge clk);
    chk("sat_count", bus4.o_cycle_count, 15);
    chk("sat_state", bus4.o_state, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
